// File: rtl/mem_req_initiator.sv
// Requester side of the split memory interface: turns a pipeline load/store into
// one word-aligned byte-masked strobe, waits for mem_resp, and returns extended
// load data with an error flag. One transaction outstanding at a time.
// Optional build macro MEM_TIMEOUT_EN adds a WAIT-state watchdog of
// TIMEOUT_CYCLES cycles that abandons a transaction whose response never arrives.
module mem_req_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    input  logic        mem_error
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // A watchdog needs at least two distinct count values to be meaningful.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    logic [1:0]        state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              we_q, we_d;
    logic              err_q, err_d;

    logic              req_ready_d;
    logic              rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic              rsp_err_d;
    logic [DATA_W-1:0] mem_addr_d;
    logic [MASK_W-1:0] mem_rmask_d;
    logic [MASK_W-1:0] mem_wmask_d;
    logic [DATA_W-1:0] mem_wdata_d;

    logic              req_legal;
    logic [MASK_W-1:0] req_mask;
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] load_data;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Request decode: alignment check and lane mask for the incoming request.
    always_comb begin
        req_legal = 1'b0;
        req_mask  = '0;
        unique case (req_size)
            SIZE_B: begin
                req_legal = 1'b1;
                req_mask  = MASK_W'(4'b0001 << req_addr[1:0]);
            end
            SIZE_H: begin
                req_legal = ~req_addr[0];
                req_mask  = MASK_W'(4'b0011 << req_addr[1:0]);
            end
            SIZE_W: begin
                req_legal = (req_addr[1:0] == 2'b00);
                req_mask  = 4'b1111;
            end
            default: begin
                req_legal = 1'b0;
                req_mask  = '0;
            end
        endcase
    end

    // Load alignment and sign/zero extension from the latched lane and size.
    always_comb begin
        rd_shift  = mem_rdata >> {lane_q, 3'b000};
        load_data = rd_shift;
        unique case (size_q)
            SIZE_B:  load_data = {{24{~uns_q & rd_shift[7]}}, rd_shift[7:0]};
            SIZE_H:  load_data = {{16{~uns_q & rd_shift[15]}}, rd_shift[15:0]};
            default: load_data = rd_shift;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        size_d      = size_q;
        uns_d       = uns_q;
        we_d        = we_q;
        err_d       = err_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_rmask_d = '0;
        mem_wmask_d = '0;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    if (!req_legal) begin
                        // Rejected without touching memory; answer next cycle.
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d     = ST_ISSUE;
                        lane_d      = req_addr[1:0];
                        size_d      = req_size;
                        uns_d       = req_unsigned;
                        we_d        = req_we;
                        err_d       = 1'b0;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wdata_d = req_wdata << {req_addr[1:0], 3'b000};
                        if (req_we) begin
                            mem_wmask_d = req_mask;
                        end else begin
                            mem_rmask_d = req_mask;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                // Strobe is up this cycle; any mem_resp here is ignored.
                err_d   = err_q | mem_error;
                state_d = ST_WAIT;
`ifdef MEM_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
                if (mem_resp) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_q | mem_error;
                    rsp_rdata_d = (we_q || err_q || mem_error) ? '0 : load_data;
                end else begin
                    err_d = err_q | mem_error;
`ifdef MEM_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d     = ST_IDLE;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            lane_q    <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_addr  <= '0;
            mem_rmask <= '0;
            mem_wmask <= '0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            we_q      <= we_d;
            err_q     <= err_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            mem_addr  <= mem_addr_d;
            mem_rmask <= mem_rmask_d;
            mem_wmask <= mem_wmask_d;
            mem_wdata <= mem_wdata_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // WAIT-state watchdog counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_req_initiator.sv
// Bench for mem_req_initiator: a one-cycle memory responder, a byte-level
// reference model feeding expectation queues, and a monitor that compares
// every strobe and every response as the DUT presents them.
`timescale 1ns/1ps
module tb_mem_req_initiator;

    localparam int unsigned TO_CYC = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_resp = 1'b0;
    logic        mem_error = 1'b0;

    mem_req_initiator #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] rdata; logic err; int due; } rsp_t;
    typedef struct { logic [31:0] addr; logic [3:0] rmask; logic [3:0] wmask;
                     logic [31:0] wdata; int due; } stb_t;
    typedef struct { string name; logic [31:0] act; logic [31:0] exp; } chk_t;

    rsp_t rsp_q[$];
    stb_t stb_q[$];
    chk_t chk_q[$];
    int   inj_q[$];

    logic [7:0]  mbyte [int];
    logic [31:0] rmem  [int];

    int checks = 0;
    int errors = 0;
    bit no_reply = 1'b0;
    int spur_req = 0;

    function automatic logic [31:0] init_word(int a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [7:0] model_rd(int a);
        logic [31:0] w;
        if (mbyte.exists(a)) return mbyte[a];
        w = init_word(a & ~3);
        return 8'(w >> (8 * (a % 4)));
    endfunction

    function automatic logic [31:0] resp_rd(int k);
        return rmem.exists(k) ? rmem[k] : init_word(k);
    endfunction

    task automatic preload(input int a, input logic [31:0] w);
        rmem[a] = w;
        for (int i = 0; i < 4; i++) mbyte[a + i] = w[8*i +: 8];
    endtask

    task automatic post(input string n, input logic [31:0] a, input logic [31:0] e);
        chk_q.push_back('{n, a, e});
    endtask

    // Issue one request at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata, input int inj,
                        input bit expect_rsp, input bit timeout, output int acc);
        int w;
        int n;
        int lane;
        bit legal;
        logic [3:0] mask;
        logic [31:0] val;
        stb_t s;
        w = 0;
        acc = -1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata;
        while (!req_ready) begin
            if (w >= 60) begin
                post("accept_timeout", 32'(w), 32'd0);
                req_valid = 1'b0;
                return;
            end
            @(negedge clk);
            w++;
        end
        acc = cyc;
        legal = (size == 2'd0) || (size == 2'd1 && !addr[0]) || (size == 2'd2 && addr[1:0] == 2'd0);
        if (!legal) begin
            if (expect_rsp) rsp_q.push_back('{32'd0, 1'b1, cyc + 1});
        end else begin
            n = 1 << size;
            lane = int'(addr[1:0]);
            mask = '0;
            for (int i = 0; i < n; i++) mask[lane + i] = 1'b1;
            s.addr  = addr & ~32'd3;
            s.rmask = we ? 4'd0 : mask;
            s.wmask = we ? mask : 4'd0;
            s.wdata = wdata << (8 * lane);
            s.due   = cyc + 1;
            stb_q.push_back(s);
            inj_q.push_back(inj);
            val = '0;
            if (we) begin
                if (inj == 0 && expect_rsp && !timeout)
                    for (int i = 0; i < n; i++) mbyte[int'(addr) + i] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) val[8*i +: 8] = model_rd(int'(addr) + i);
                if (!uns && n < 4 && val[8*n - 1]) val = val | ~((32'd1 << (8*n)) - 32'd1);
            end
            if (expect_rsp) begin
                if (inj != 0 || timeout)
                    rsp_q.push_back('{32'd0, 1'b1, timeout ? cyc + 2 + int'(TO_CYC) : cyc + 3});
                else
                    rsp_q.push_back('{val, 1'b0, cyc + 3});
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic drain(input string n);
        int w;
        w = 0;
        while (rsp_q.size() != 0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        post(n, 32'(rsp_q.size()), 32'd0);
    endtask

    task automatic quiet_window(input string n, input int len);
        int seen;
        seen = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        post(n, 32'(seen), 32'd0);
    endtask

    // One-cycle memory responder: latches the strobe, replies the following cycle.
    initial begin
        int pend;
        int pk;
        int inj_now;
        int inj_pend;
        int spur_done;
        logic [31:0] wd;
        pend = 0; pk = 0; inj_pend = 0; spur_done = 0;
        forever begin
            @(negedge clk);
            mem_resp = 1'b0;
            mem_error = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else begin
                if (spur_req != spur_done) begin
                    spur_done = spur_req;
                    mem_resp = 1'b1;
                    mem_error = 1'b1;
                    mem_rdata = $urandom;
                end
                if (pend != 0) begin
                    mem_resp = 1'b1;
                    mem_rdata = resp_rd(pk);
                    if (inj_pend == 2) mem_error = 1'b1;
                    pend = 0;
                end
                if (mem_rmask != 4'd0 || mem_wmask != 4'd0) begin
                    inj_now = (inj_q.size() != 0) ? inj_q.pop_front() : 0;
                    if (inj_now == 1) mem_error = 1'b1;
                    if (mem_wmask != 4'd0 && inj_now == 0 && !no_reply) begin
                        wd = resp_rd(int'(mem_addr));
                        for (int i = 0; i < 4; i++)
                            if (mem_wmask[i]) wd[8*i +: 8] = mem_wdata[8*i +: 8];
                        rmem[int'(mem_addr)] = wd;
                    end
                    if (!no_reply) begin
                        pend = 1;
                        pk = int'(mem_addr);
                        inj_pend = inj_now;
                    end
                end
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    // Monitor: compares strobes and responses against the expectation queues.
    initial begin
        stb_t s;
        rsp_t r;
        chk_t c;
        forever begin
            @(negedge clk);
            while (chk_q.size() != 0) begin
                c = chk_q.pop_front();
                chk(c.name, c.act, c.exp);
            end
            if (rst_n) begin
                if (mem_rmask != 4'd0 || mem_wmask != 4'd0) begin
                    chk("strobe_expected", 32'(stb_q.size() != 0), 32'd1);
                    if (stb_q.size() != 0) begin
                        s = stb_q.pop_front();
                        chk("mem_addr", mem_addr, s.addr);
                        chk("mem_rmask", 32'(mem_rmask), 32'(s.rmask));
                        chk("mem_wmask", 32'(mem_wmask), 32'(s.wmask));
                        chk("mem_wdata", mem_wdata, s.wdata);
                        chk("strobe_cycle", 32'(cyc), 32'(s.due));
                    end
                end
                if (rsp_valid) begin
                    chk("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
                    if (rsp_q.size() != 0) begin
                        r = rsp_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, r.rdata);
                        chk("rsp_err", 32'(rsp_err), 32'(r.err));
                        chk("rsp_cycle", 32'(cyc), 32'(r.due));
                    end
                end
            end
        end
    end

    // Stimulus sequence.
    initial begin
        int acc;
        int a4 [4];
        int r;
        logic [1:0] sz;

        repeat (3) @(negedge clk);
        post("rst_req_ready", 32'(req_ready), 32'd0);
        post("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        post("rst_rsp_rdata", rsp_rdata, 32'd0);
        post("rst_rsp_err", 32'(rsp_err), 32'd0);
        post("rst_mem_addr", mem_addr, 32'd0);
        post("rst_mem_rmask", 32'(mem_rmask), 32'd0);
        post("rst_mem_wmask", 32'(mem_wmask), 32'd0);
        post("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed loads, stores and a misaligned request.
        preload(32'h1000, 32'h8765_4321);
        preload(32'h2000, 32'h1234_5678);
        send(1'b0, 32'h1000, 2'd2, 1'b0, 32'd0, 0, 1'b1, 1'b0, acc);
        send(1'b0, 32'h1003, 2'd0, 1'b0, 32'd0, 0, 1'b1, 1'b0, acc);
        send(1'b0, 32'h1003, 2'd0, 1'b1, 32'd0, 0, 1'b1, 1'b0, acc);
        send(1'b1, 32'h2002, 2'd1, 1'b0, 32'h0000_BEEF, 0, 1'b1, 1'b0, acc);
        send(1'b0, 32'h2000, 2'd2, 1'b0, 32'd0, 0, 1'b1, 1'b0, acc);
        send(1'b0, 32'h1001, 2'd2, 1'b0, 32'd0, 0, 1'b1, 1'b0, acc);
        send(1'b0, 32'h1002, 2'd3, 1'b0, 32'd0, 0, 1'b1, 1'b0, acc);
        send(1'b0, 32'h1002, 2'd1, 1'b0, 32'd0, 0, 1'b1, 1'b0, acc);
        idle(1);
        drain("directed_drain");

        // Back-to-back loads with req_valid held throughout.
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 32'h1000 + 32'(4*i), 2'd2, 1'b0, 32'd0, 0, 1'b1, 1'b0, acc);
            a4[i] = acc;
        end
        idle(1);
        post("b2b_gap01", 32'(a4[1] - a4[0]), 32'd3);
        post("b2b_span", 32'(a4[3] - a4[0]), 32'd9);
        drain("b2b_drain");
        spur_req++;
        quiet_window("idle_spurious_resp", 5);

        // Randomized traffic with occasional memory-side errors.
        for (int t = 0; t < 250; t++) begin
            r = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            r = $urandom_range(0, 9);
            send(1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 63)), sz,
                 1'($urandom_range(0, 1)), $urandom, (r == 0) ? 1 : (r == 1) ? 2 : 0,
                 1'b1, 1'b0, acc);
            r = $urandom_range(0, 3);
            if (r < 2) idle(r);
        end
        idle(1);
        drain("random_drain");

        // Reset dropped while the DUT waits for a response.
        no_reply = 1'b1;
        send(1'b0, 32'h1000, 2'd2, 1'b0, 32'd0, 0, 1'b0, 1'b0, acc);
        idle(1);
        #2 rst_n = 1'b0;
        #1;
        post("arst_mem_rmask", 32'(mem_rmask), 32'd0);
        post("arst_mem_addr", mem_addr, 32'd0);
        post("arst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        no_reply = 1'b0;
        spur_req++;
        quiet_window("post_reset_resp", 5);

`ifdef MEM_TIMEOUT_EN
        // Responder never answers: watchdog must abandon the transaction.
        no_reply = 1'b1;
        send(1'b0, 32'h1004, 2'd2, 1'b0, 32'd0, 0, 1'b1, 1'b1, acc);
        idle(1);
        drain("timeout_drain");
        no_reply = 1'b0;
        spur_req++;
        quiet_window("late_resp_ignored", 5);
`endif

        idle(2);
        post("final_rsp_queue", 32'(rsp_q.size()), 32'd0);
        post("final_stb_queue", 32'(stb_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_req_initiator.md
Name: mem_req_initiator

Overview:
- Requester end of the split memory interface (addr / rmask / wmask / wdata / rdata / resp / error) used by the magic dual-port memory model and the core's memory ports.
- Accepts load/store requests from a pipeline stage over valid/ready.
- Converts each request into one word-aligned, byte-masked memory strobe, then waits for the response.
- Returns aligned, sign- or zero-extended load data with an error flag; one transaction outstanding at a time.

Parameters:
TIMEOUT_CYCLES, 256, WAIT-state cycles before a transaction is abandoned (used only when MEM_TIMEOUT_EN is defined)

Ports:
clk  in  1  clock; all state on posedge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  pipeline request valid
req_ready  out  1  block can accept a request
req_we  in  1  1=store, 0=load
req_addr  in  32  byte address
req_size  in  2  00=byte, 01=half, 10=word; 11 is illegal
req_unsigned  in  1  zero-extend load data when 1, sign-extend when 0
req_wdata  in  32  store data, right-justified
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  qualifies rsp_valid
mem_addr  out  32  {req_addr[31:2],2'b00}
mem_rmask  out  4  byte read strobe
mem_wmask  out  4  byte write strobe
mem_wdata  out  32  store data shifted to byte lane
mem_rdata  in  32  memory read data
mem_resp  in  1  memory response
mem_error  in  1  memory-side protocol error

Behaviour:
- Reset: while rst_n is low, all outputs are 0, req_ready is 0 and the state is IDLE. Reset takes effect asynchronously, including mid-transaction; masks drop immediately and any in-flight response is discarded.
- States:
  - IDLE: req_ready = 1.
  - ISSUE: exactly one cycle.
  - WAIT: request retired.
- IDLE -> ISSUE on req_valid & req_ready:
  - Latch addr[1:0], size, unsigned and we.
  - Register mem_addr.
  - Register mem_wdata = req_wdata << (8*addr[1:0]).
  - Register mask = base << addr[1:0], where base is 0001 for byte, 0011 for half, 1111 for word.
  - The mask drives mem_wmask if we, else mem_rmask; the other mask stays 0.
- Misaligned or illegal request: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - No memory strobe is issued; state stays IDLE.
  - rsp_valid=1, rsp_err=1, rsp_rdata=0 in the next cycle.
- ISSUE -> WAIT unconditionally. Masks are nonzero for exactly one cycle per transaction; the responder latches the strobe. mem_resp during ISSUE is ignored.
- WAIT: masks are 0 and mem_addr / mem_wdata are held stable. On mem_resp=1, move to IDLE and, in the next cycle, pulse rsp_valid for one cycle.
- Load data: shift mem_rdata right by 8*addr[1:0], then extend from bit 7 (byte) or bit 15 (half) per req_unsigned; a word passes through unchanged. Stores return rsp_rdata=0.
- mem_error high in any ISSUE/WAIT cycle sets a sticky flag that is reported as rsp_err on that transaction's response. The flag is cleared on accept.
- mem_resp or mem_error while IDLE is ignored; a spurious response never creates rsp_valid.
- rsp_valid coincides with the IDLE state, so a new request may be accepted in the same cycle as the response (back-to-back).
- Timing against a one-cycle responder:
  - Accept edge E0; strobe in cycle 0.
  - mem_resp in cycle 1.
  - rsp_valid in cycle 2.
  - Sustained throughput is one transaction per 3 cycles.

Optional Feature:
MEM_TIMEOUT_EN
- Defined: a WAIT cycle counter counts up from 0. If it reaches TIMEOUT_CYCLES-1 without mem_resp, the block returns to IDLE and pulses rsp_valid with rsp_err=1 and rsp_rdata=0. A late mem_resp arriving in IDLE is ignored.
- Undefined: no counter is built; WAIT holds indefinitely until mem_resp.

Test Plan:
- Word load at 0x0000_1000, memory word 0x8765_4321 -> one-cycle mem_rmask=1111 with mem_addr=0x1000; rsp_valid two cycles after the strobe with rsp_rdata=0x8765_4321 and rsp_err=0.
- Byte load at 0x1003, signed, then unsigned, with memory word 0x8765_4321 -> mem_rmask=1000; rsp_rdata=0xFFFF_FF87, then 0x0000_0087.
- Half store 0xBEEF at 0x2002 -> mem_wmask=1100 and mem_wdata=0xBEEF_xxxx (bits 31:16 = 0xBEEF) for one cycle; then a word load of 0x2000 returns 0xBEEF in bits 31:16 with bits 15:0 unchanged.
- Word load at 0x1001 -> no nonzero mask ever; rsp_valid with rsp_err=1 and rsp_rdata=0 the next cycle.
- Back-to-back: req_valid held across 4 loads -> accepts exactly at rsp_valid cycles; 4 responses in 12 cycles; mem_resp asserted while IDLE produces no rsp_valid.
- rst_n dropped while in WAIT, then mem_resp pulsed after release -> masks 0 immediately; no rsp_valid. With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, a responder that never replies -> rsp_err=1 after 8 WAIT cycles.
